// File: rtl/enc_pkg.sv
// Shared types, constants and the quadrature step decoder for the encoder speed meter.
package enc_pkg;

    localparam int CNT_W          = 32;
    localparam int DEFAULT_WINDOW = 500000;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_FWD,
        STEP_REV,
        STEP_ILLEGAL
    } step_t;

    typedef enum logic {
        DEC_INIT,
        DEC_RUN
    } dec_state_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; both bits flipping at once cannot be a real step.
    function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        step_t s;
        s = STEP_NONE;
        case ({prev_ab, cur_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_FWD;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_REV;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = STEP_ILLEGAL;
            default:                                s = STEP_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/enc_input_filter.sv
// Two-flop synchronizer followed by a glitch filter that only follows the input
// after it has held a new level for FILTER_LEN consecutive cycles.
module enc_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic       sync_meta;
    logic       sync_out;
    logic [7:0] stable_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= din;
            sync_out  <= sync_meta;
        end
    end

    // Any cycle where the synchronized level matches the output restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_out == dout) begin
            stable_cnt <= '0;
        end else if (stable_cnt == 8'(FILTER_LEN - 1)) begin
            dout       <= sync_out;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/enc_speed_meter.sv
// Quadrature encoder position counter with windowed speed measurement and a
// coherent position/speed snapshot pair for SPI readout.
module enc_speed_meter
    import enc_pkg::*;
#(
    parameter int FILTER_LEN    = 4,
    parameter int WINDOW_CYCLES = DEFAULT_WINDOW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    latch,
    input  logic                    clear,
    output logic signed [CNT_W-1:0] position,
    output logic signed [CNT_W-1:0] speed,
    output logic                    speed_valid,
    output logic signed [CNT_W-1:0] snap_position,
    output logic signed [CNT_W-1:0] snap_speed,
    output logic                    snap_valid,
    output logic                    dir,
    output logic                    error
);

    localparam int              WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic                    filt_a;
    logic                    filt_b;
    logic [1:0]              cur_ab;
    logic [1:0]              prev_ab;
    dec_state_t              state;
    dec_state_t              state_next;
    step_t                   step;
    logic signed [CNT_W-1:0] step_delta;
    logic signed [CNT_W-1:0] pos_next;
    logic signed [CNT_W-1:0] accum;
    logic signed [CNT_W-1:0] acc_sum;
    logic [WIN_W-1:0]        win_cnt;
    logic                    win_tc;

    enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk   (clk),
        .reset (reset),
        .din   (enc_a),
        .dout  (filt_a)
    );

    enc_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk   (clk),
        .reset (reset),
        .din   (enc_b),
        .dout  (filt_b)
    );

    assign cur_ab = {filt_a, filt_b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= DEC_INIT;
            prev_ab <= 2'b00;
        end else begin
            state   <= state_next;
            prev_ab <= cur_ab;
        end
    end

    // The init phase only primes prev_ab; clear forces a fresh init and swallows any step.
    always_comb begin
        state_next = state;
        step       = STEP_NONE;
        case (state)
            DEC_INIT: state_next = DEC_RUN;
            DEC_RUN:  step       = decode_step(prev_ab, cur_ab);
            default:  state_next = DEC_INIT;
        endcase
        if (clear) begin
            state_next = DEC_INIT;
            step       = STEP_NONE;
        end
    end

    always_comb begin
        step_delta = '0;
        case (step)
            STEP_FWD: step_delta = {{(CNT_W-1){1'b0}}, 1'b1};
            STEP_REV: step_delta = '1;
            default:  step_delta = '0;
        endcase
    end

    assign pos_next = clear ? '0 : position + step_delta;
    assign acc_sum  = accum + step_delta;
    assign win_tc   = (win_cnt == WIN_LAST);

    // Position is rewritten every cycle from its current value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            position <= '0;
            dir      <= 1'b0;
            error    <= 1'b0;
        end else begin
            position <= pos_next;
            if (step == STEP_FWD) begin
                dir <= 1'b1;
            end else if (step == STEP_REV) begin
                dir <= 1'b0;
            end
            if (clear) begin
                error <= 1'b0;
            end else if (step == STEP_ILLEGAL) begin
                error <= 1'b1;
            end
        end
    end

    // The terminal count publishes speed even when clear arrives in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed       <= '0;
            speed_valid <= 1'b0;
            accum       <= '0;
            win_cnt     <= '0;
        end else begin
            speed_valid <= win_tc;
            if (win_tc) begin
                speed   <= acc_sum;
                accum   <= '0;
                win_cnt <= '0;
            end else if (clear) begin
                accum   <= '0;
                win_cnt <= '0;
            end else begin
                accum   <= acc_sum;
                win_cnt <= win_cnt + WIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_position <= '0;
            snap_speed    <= '0;
            snap_valid    <= 1'b0;
        end else begin
            snap_valid <= latch;
            if (latch) begin
                snap_position <= position;
                snap_speed    <= speed;
            end
        end
    end

endmodule

// File: tb/tb_enc_speed_meter.sv
// Self-checking bench for enc_speed_meter: directed scenarios plus random encoder
// traffic, all compared every cycle against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_enc_speed_meter;

    localparam int FL  = 4;
    localparam int WIN = 1000;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        pins  = 2'b00;
    logic              latch = 1'b0;
    logic              clear = 1'b0;
    logic signed [31:0] position;
    logic signed [31:0] speed;
    logic signed [31:0] snap_position;
    logic signed [31:0] snap_speed;
    logic              speed_valid;
    logic              snap_valid;
    logic              dir;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    enc_speed_meter #(.FILTER_LEN(FL), .WINDOW_CYCLES(WIN)) dut (
        .clk           (clk),
        .reset         (reset),
        .enc_a         (pins[1]),
        .enc_b         (pins[0]),
        .latch         (latch),
        .clear         (clear),
        .position      (position),
        .speed         (speed),
        .speed_valid   (speed_valid),
        .snap_position (snap_position),
        .snap_speed    (snap_speed),
        .snap_valid    (snap_valid),
        .dir           (dir),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [1:0]  m_pins[$];
    logic [1:0]  m_fhist[$];
    logic [1:0]  m_filt     = 2'b00;
    logic [1:0]  m_prev     = 2'b00;
    bit          m_init     = 1'b1;
    logic [31:0] m_pos      = '0;
    logic [31:0] m_acc      = '0;
    logic [31:0] m_speed    = '0;
    logic [31:0] m_snap_pos = '0;
    logic [31:0] m_snap_spd = '0;
    bit          m_sv       = 1'b0;
    bit          m_snap_v   = 1'b0;
    bit          m_dir      = 1'b0;
    bit          m_err      = 1'b0;
    int          m_wcnt     = 0;

    function automatic int gray_idx(input logic [1:0] c);
        case (c)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_code(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] next_fwd(input logic [1:0] c);
        return gray_code(gray_idx(c) + 1);
    endfunction

    function automatic logic [1:0] next_rev(input logic [1:0] c);
        return gray_code(gray_idx(c) + 3);
    endfunction

    task automatic model_reset();
        m_pins.delete();
        m_pins.push_back(2'b00);
        m_pins.push_back(2'b00);
        m_fhist.delete();
        m_filt = 2'b00; m_prev = 2'b00; m_init = 1'b1;
        m_pos = '0; m_acc = '0; m_speed = '0; m_snap_pos = '0; m_snap_spd = '0;
        m_sv = 1'b0; m_snap_v = 1'b0; m_dir = 1'b0; m_err = 1'b0; m_wcnt = 0;
    endtask

    task automatic model_step();
        logic [1:0]  cur;
        logic [1:0]  in_s;
        logic [31:0] old_pos;
        logic [31:0] old_spd;
        int          d;
        int          diff;
        bit          illegal;
        bit          all_diff;
        cur     = m_filt;
        old_pos = m_pos;
        old_spd = m_speed;
        d       = 0;
        illegal = 1'b0;
        if (!m_init) begin
            diff = (gray_idx(cur) - gray_idx(m_prev) + 4) % 4;
            if (diff == 1)      d = 1;
            else if (diff == 3) d = -1;
            else if (diff == 2) illegal = 1'b1;
        end
        m_sv = 1'b0;
        if (clear) begin
            if (m_wcnt == WIN - 1) begin
                m_speed = m_acc;
                m_sv    = 1'b1;
            end
            m_pos = '0; m_err = 1'b0; m_acc = '0; m_wcnt = 0; m_init = 1'b1;
        end else begin
            m_init = 1'b0;
            m_prev = cur;
            m_pos  = m_pos + 32'(d);
            m_acc  = m_acc + 32'(d);
            if (d > 0) m_dir = 1'b1;
            if (d < 0) m_dir = 1'b0;
            if (illegal) m_err = 1'b1;
            if (m_wcnt == WIN - 1) begin
                m_speed = m_acc;
                m_acc   = '0;
                m_sv    = 1'b1;
                m_wcnt  = 0;
            end else begin
                m_wcnt++;
            end
        end
        m_snap_v = latch;
        if (latch) begin
            m_snap_pos = old_pos;
            m_snap_spd = old_spd;
        end
        // Pins reach the filter two edges after being sampled.
        in_s = m_pins.pop_front();
        m_pins.push_back(pins);
        m_fhist.push_back(in_s);
        if (m_fhist.size() > FL) void'(m_fhist.pop_front());
        if (m_fhist.size() == FL) begin
            for (int c = 0; c < 2; c++) begin
                all_diff = 1'b1;
                foreach (m_fhist[k]) if (m_fhist[k][c] == m_filt[c]) all_diff = 1'b0;
                if (all_diff) m_filt[c] = ~m_filt[c];
            end
        end
    endtask

    always @(posedge clk) begin
        cyc_cnt++;
        if (!reset) model_reset();
        else        model_step();
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, act, exp, cyc_cnt);
        end
    endtask

    always @(posedge clk) begin
        #2;
        check_output("position",      position,      m_pos);
        check_output("speed",         speed,         m_speed);
        check_output("speed_valid",   32'(speed_valid), 32'(m_sv));
        check_output("snap_position", snap_position, m_snap_pos);
        check_output("snap_speed",    snap_speed,    m_snap_spd);
        check_output("snap_valid",    32'(snap_valid), 32'(m_snap_v));
        check_output("dir",           32'(dir),      32'(m_dir));
        check_output("error",         32'(error),    32'(m_err));
    end

    task automatic apply_stimulus(input logic [1:0] code, input int hold);
        @(negedge clk);
        pins = code;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic wait_speed_valid(output int at_cycle);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2100 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (speed_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("[TB] FAIL speed_valid_timeout: got no pulse, expected one within 2100 cycles");
        end
        at_cycle = cyc_cnt;
    endtask

    initial begin
        #1ms;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int c1;
        int c_rel;
        model_reset();
        repeat (3) @(negedge clk);
        check_output("reset_position", position, 32'd0);
        check_output("reset_speed",    speed,    32'd0);
        check_output("reset_error",    32'(error), 32'd0);
        check_output("reset_dir",      32'(dir),   32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        // Eight forward steps; the first one also pins the pin-to-position latency.
        pins = 2'b01;
        repeat (FL + 2) @(posedge clk);
        #2 check_output("latency_before", position, 32'd0);
        @(posedge clk);
        #2 check_output("latency_at", position, 32'd1);
        repeat (13) @(negedge clk);
        for (int i = 1; i < 8; i++) apply_stimulus(next_fwd(pins), 20);
        check_output("fwd8_position", position, 32'd8);
        check_output("fwd8_dir",      32'(dir), 32'd1);
        check_output("fwd8_model",    m_pos,    32'd8);

        // Short pulse on A must be filtered out.
        apply_stimulus(2'b10, 3);
        apply_stimulus(2'b00, 20);
        check_output("glitch_position", position, 32'd8);
        check_output("glitch_error",    32'(error), 32'd0);

        // Illegal jump, then clear and the init-only sample that follows.
        apply_stimulus(2'b11, 20);
        check_output("illegal_error",    32'(error), 32'd1);
        check_output("illegal_position", position,   32'd8);
        pulse_clear();
        check_output("clear_error",    32'(error), 32'd0);
        check_output("clear_position", position,   32'd0);
        repeat (10) @(negedge clk);
        check_output("init_position", position,   32'd0);
        check_output("init_error",    32'(error), 32'd0);
        apply_stimulus(next_fwd(pins), 20);
        check_output("post_init_step", position, 32'd1);

        // Fifty reverse steps inside one window, then an idle window.
        wait_speed_valid(c0);
        for (int i = 0; i < 50; i++) apply_stimulus(next_rev(pins), 10);
        check_output("rev_dir", 32'(dir), 32'd0);
        wait_speed_valid(c1);
        check_output("rev_speed",    speed,   32'hFFFF_FFCE);
        check_output("rev_interval", c1 - c0, 32'd1000);
        wait_speed_valid(c0);
        check_output("idle_speed",    speed,   32'd0);
        check_output("idle_interval", c0 - c1, 32'd1000);

        // Wrap below zero, then wrap past the positive limit.
        pulse_clear();
        repeat (3) @(negedge clk);
        apply_stimulus(next_rev(pins), 20);
        check_output("wrap_neg", position, 32'hFFFF_FFFF);
        @(negedge clk);
        force dut.position = 32'sh7FFF_FFFF;
        m_pos = 32'h7FFF_FFFF;
        @(negedge clk);
        release dut.position;
        apply_stimulus(next_fwd(pins), 20);
        check_output("wrap_pos", position, 32'h8000_0000);

        // Latch together with clear on the terminal-count cycle.
        pulse_clear();
        wait_speed_valid(c0);
        for (int i = 0; i < 5; i++) apply_stimulus(next_fwd(pins), 10);
        wait_speed_valid(c1);
        check_output("win5_speed",    speed,    32'd5);
        check_output("win5_position", position, 32'd5);
        for (int i = 0; i < 2; i++) apply_stimulus(next_fwd(pins), 10);
        while (cyc_cnt < c1 + WIN - 1) @(negedge clk);
        latch = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #2;
        check_output("tc_snap_speed",    snap_speed,    32'd5);
        check_output("tc_snap_position", snap_position, 32'd7);
        check_output("tc_snap_valid",    32'(snap_valid), 32'd1);
        check_output("tc_speed",         speed,         32'd2);
        check_output("tc_speed_valid",   32'(speed_valid), 32'd1);
        check_output("tc_position",      position,      32'd0);
        @(negedge clk);
        latch = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        #2 check_output("tc_snap_valid_drop", 32'(snap_valid), 32'd0);

        // Reset in the middle of a window discards the partial count.
        repeat (300) @(negedge clk);
        apply_stimulus(next_fwd(pins), 10);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("midreset_speed",    speed,    32'd0);
        check_output("midreset_position", position, 32'd0);
        reset = 1'b1;
        c_rel = cyc_cnt;
        wait_speed_valid(c0);
        check_output("midreset_interval", c0 - c_rel, 32'd1000);

        // Random encoder traffic with occasional latch and clear.
        begin
            int hold_left;
            int r;
            hold_left = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                if (hold_left == 0) begin
                    r = $urandom_range(0, 99);
                    if (r < 40)      pins = next_fwd(pins);
                    else if (r < 80) pins = next_rev(pins);
                    else if (r < 90) pins = ~pins;
                    hold_left = $urandom_range(1, 14);
                end
                hold_left--;
                latch = ($urandom_range(0, 49) == 0);
                clear = ($urandom_range(0, 199) == 0);
            end
            @(negedge clk);
            latch = 1'b0;
            clear = 1'b0;
            repeat (20) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
